// File: rtl/alu_rs_multi_cdb.sv
// ALU reservation station: buffers dispatched ops until their operands arrive on the CDB,
// issues the oldest ready entry through a one-stage ALU, and holds the result on a valid/ready port.
module alu_rs_multi_cdb #(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_WIDTH = 4,
  parameter int NUM_CDB   = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            flush_in,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [ROB_WIDTH-1:0]            disp_rob_idx,
  input  logic [6:0]                      disp_opcode,
  input  logic [31:0]                     disp_vj,
  input  logic [31:0]                     disp_vk,
  input  logic [ROB_WIDTH:0]              disp_qj,
  input  logic [ROB_WIDTH:0]              disp_qk,
  input  logic [31:0]                     disp_imm,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB*ROB_WIDTH-1:0]    cdb_idx,
  input  logic [NUM_CDB*32-1:0]           cdb_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROB_WIDTH-1:0]            out_rob_idx,
  output logic [31:0]                     out_data,
  output logic [$clog2(RS_DEPTH+1)-1:0]   count,
  output logic                            empty,
  output logic                            full
);

  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int IW = $clog2(RS_DEPTH);
  localparam logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};

  logic [RS_DEPTH-1:0]  ent_valid;
  logic [ROB_WIDTH-1:0] ent_rob [RS_DEPTH];
  logic [6:0]           ent_op  [RS_DEPTH];
  logic [31:0]          ent_vj  [RS_DEPTH];
  logic [31:0]          ent_vk  [RS_DEPTH];
  logic [31:0]          ent_imm [RS_DEPTH];
  logic [ROB_WIDTH:0]   ent_qj  [RS_DEPTH];
  logic [ROB_WIDTH:0]   ent_qk  [RS_DEPTH];
  // older[i][j] = 1 when entry j was allocated before entry i
  logic [RS_DEPTH-1:0]  older   [RS_DEPTH];

  logic [32:0]          wake_j  [RS_DEPTH];
  logic [32:0]          wake_k  [RS_DEPTH];
  logic [32:0]          disp_j, disp_k;
  logic [RS_DEPTH-1:0]  ready, issue_oh;
  logic [IW-1:0]        issue_idx, alloc_idx;
  logic                 out_accept, issue_fire, alloc;
  logic [31:0]          issue_result;

  // Returns {hit, data}; the descending loop lets the lowest CDB port win, and any CDB hit
  // overrides the accepted output.
  function automatic logic [32:0] snoop(
    input logic [ROB_WIDTH:0]           tag,
    input logic [NUM_CDB-1:0]           v,
    input logic [NUM_CDB*ROB_WIDTH-1:0] idx,
    input logic [NUM_CDB*32-1:0]        data,
    input logic                         acc,
    input logic [ROB_WIDTH-1:0]         acc_idx,
    input logic [31:0]                  acc_data
  );
    logic [32:0] r;
    r = '0;
    if (acc && tag == {1'b0, acc_idx}) r = {1'b1, acc_data};
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (v[p] && tag == {1'b0, idx[p*ROB_WIDTH +: ROB_WIDTH]}) r = {1'b1, data[p*32 +: 32]};
    end
    return r;
  endfunction

  function automatic logic [31:0] alu_calc(
    input logic [6:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] imm
  );
    logic [31:0] rhs;
    logic [31:0] r;
    rhs = (op >= 7'd28) ? b : imm;
    r = '0;
    case (op)
      7'd4:          r = (a + imm) & ~32'd1;
      7'd5:          r = {31'd0, a == b};
      7'd6:          r = {31'd0, a != b};
      7'd7:          r = {31'd0, $signed(a) < $signed(b)};
      7'd8:          r = {31'd0, $signed(a) >= $signed(b)};
      7'd9:          r = {31'd0, a < b};
      7'd10:         r = {31'd0, a >= b};
      7'd19, 7'd28:  r = a + rhs;
      7'd29:         r = a - b;
      7'd20, 7'd31:  r = {31'd0, $signed(a) < $signed(rhs)};
      7'd21, 7'd32:  r = {31'd0, a < rhs};
      7'd22, 7'd33:  r = a ^ rhs;
      7'd23, 7'd36:  r = a | rhs;
      7'd24, 7'd37:  r = a & rhs;
      7'd25, 7'd30:  r = a << rhs[4:0];
      7'd26, 7'd34:  r = a >> rhs[4:0];
      7'd27, 7'd35:  r = $signed(a) >>> rhs[4:0];
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign full       = (count == CW'(RS_DEPTH));
  assign empty      = (count == '0);
  assign disp_ready = !full;
  assign out_accept = out_valid && out_ready;
  assign alloc      = disp_valid && !full;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake_j[i] = snoop(ent_qj[i], cdb_valid, cdb_idx, cdb_data, out_accept, out_rob_idx, out_data);
      wake_k[i] = snoop(ent_qk[i], cdb_valid, cdb_idx, cdb_data, out_accept, out_rob_idx, out_data);
    end
    disp_j = snoop(disp_qj, cdb_valid, cdb_idx, cdb_data, out_accept, out_rob_idx, out_data);
    disp_k = snoop(disp_qk, cdb_valid, cdb_idx, cdb_data, out_accept, out_rob_idx, out_data);
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = ent_valid[i] && ent_qj[i] == NON_DEP && ent_qk[i] == NON_DEP;
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      issue_oh[i] = ready[i] && ((older[i] & ready) == '0);
    end
  end

  always_comb begin
    issue_idx = '0;
    alloc_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (issue_oh[i]) issue_idx = IW'(i);
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) alloc_idx = IW'(i);
    end
  end

  assign issue_fire   = (|ready) && (!out_valid || out_ready);
  assign issue_result = alu_calc(ent_op[issue_idx], ent_vj[issue_idx], ent_vk[issue_idx],
                                 ent_imm[issue_idx]);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ent_valid   <= '0;
      out_valid   <= 1'b0;
      out_rob_idx <= '0;
      out_data    <= '0;
      count       <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_rob[i] <= '0;
        ent_op[i]  <= '0;
        ent_vj[i]  <= '0;
        ent_vk[i]  <= '0;
        ent_imm[i] <= '0;
        ent_qj[i]  <= NON_DEP;
        ent_qk[i]  <= NON_DEP;
        older[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        ent_valid <= '0;
        out_valid <= 1'b0;
        count     <= '0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (ent_valid[i] && wake_j[i][32]) begin
            ent_qj[i] <= NON_DEP;
            ent_vj[i] <= wake_j[i][31:0];
          end
          if (ent_valid[i] && wake_k[i][32]) begin
            ent_qk[i] <= NON_DEP;
            ent_vk[i] <= wake_k[i][31:0];
          end
        end

        if (issue_fire) begin
          ent_valid[issue_idx] <= 1'b0;
          out_valid            <= 1'b1;
          out_rob_idx          <= ent_rob[issue_idx];
          out_data             <= issue_result;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end

        if (alloc) begin
          ent_valid[alloc_idx] <= 1'b1;
          ent_rob[alloc_idx]   <= disp_rob_idx;
          ent_op[alloc_idx]    <= disp_opcode;
          ent_imm[alloc_idx]   <= disp_imm;
          ent_qj[alloc_idx]    <= disp_j[32] ? NON_DEP : disp_qj;
          ent_vj[alloc_idx]    <= disp_j[32] ? disp_j[31:0] : disp_vj;
          ent_qk[alloc_idx]    <= disp_k[32] ? NON_DEP : disp_qk;
          ent_vk[alloc_idx]    <= disp_k[32] ? disp_k[31:0] : disp_vk;
          older[alloc_idx]     <= ent_valid;
          // a reused slot must not look older than anything still waiting
          for (int i = 0; i < RS_DEPTH; i++) older[i][alloc_idx] <= 1'b0;
        end

        count <= count + {{(CW-1){1'b0}}, alloc} - {{(CW-1){1'b0}}, issue_fire};
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_multi_cdb.sv
// Bench for alu_rs_multi_cdb: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_alu_rs_multi_cdb;
  localparam int D  = 16;
  localparam int RW = 4;
  localparam int NC = 2;
  localparam logic [RW:0] NON = 5'b10000;

  logic            clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
  logic            disp_valid = 1'b0, disp_ready;
  logic [RW-1:0]   disp_rob_idx = '0;
  logic [6:0]      disp_opcode = '0;
  logic [31:0]     disp_vj = '0, disp_vk = '0, disp_imm = '0;
  logic [RW:0]     disp_qj = NON, disp_qk = NON;
  logic [NC-1:0]   cdb_valid = '0;
  logic [NC*RW-1:0] cdb_idx = '0;
  logic [NC*32-1:0] cdb_data = '0;
  logic            out_valid, out_ready = 1'b1;
  logic [RW-1:0]   out_rob_idx;
  logic [31:0]     out_data;
  logic [4:0]      count;
  logic            empty, full;

  alu_rs_multi_cdb #(.RS_DEPTH(D), .ROB_WIDTH(RW), .NUM_CDB(NC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
    .disp_opcode(disp_opcode), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_imm(disp_imm),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_idx(out_rob_idx),
    .out_data(out_data), .count(count), .empty(empty), .full(full)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [RW-1:0] rob;
    logic [6:0]    op;
    logic [31:0]   vj, vk, imm;
    logic [RW:0]   qj, qk;
  } ent_t;

  ent_t          mq[$];
  logic          m_ov = 1'b0;
  logic [RW-1:0] m_rob = '0;
  logic [31:0]   m_data = '0;
  logic          m_acc, m_alloc;
  int            m_pick;
  ent_t          m_ne, m_e;
  logic [32:0]   m_s;

  function automatic logic [31:0] m_alu(input ent_t e);
    int sa, sb, si;
    sa = e.vj; sb = e.vk; si = e.imm;
    case (e.op)
      4:  return (e.vj + e.imm) & 32'hFFFF_FFFE;
      5:  return (e.vj == e.vk) ? 32'd1 : 32'd0;
      6:  return (e.vj != e.vk) ? 32'd1 : 32'd0;
      7:  return (sa < sb) ? 32'd1 : 32'd0;
      8:  return (sa >= sb) ? 32'd1 : 32'd0;
      9:  return (e.vj < e.vk) ? 32'd1 : 32'd0;
      10: return (e.vj >= e.vk) ? 32'd1 : 32'd0;
      19: return e.vj + e.imm;
      20: return (sa < si) ? 32'd1 : 32'd0;
      21: return (e.vj < e.imm) ? 32'd1 : 32'd0;
      22: return e.vj ^ e.imm;
      23: return e.vj | e.imm;
      24: return e.vj & e.imm;
      25: return e.vj << e.imm[4:0];
      26: return e.vj >> e.imm[4:0];
      27: return 32'(sa >>> e.imm[4:0]);
      28: return e.vj + e.vk;
      29: return e.vj - e.vk;
      30: return e.vj << e.vk[4:0];
      31: return (sa < sb) ? 32'd1 : 32'd0;
      32: return (e.vj < e.vk) ? 32'd1 : 32'd0;
      33: return e.vj ^ e.vk;
      34: return e.vj >> e.vk[4:0];
      35: return 32'(sa >>> e.vk[4:0]);
      36: return e.vj | e.vk;
      37: return e.vj & e.vk;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [32:0] m_snoop(input logic [RW:0] tag, input logic acc);
    if (tag[RW]) return 33'd0;
    for (int p = 0; p < NC; p++)
      if (cdb_valid[p] && cdb_idx[p*RW +: RW] == tag[RW-1:0]) return {1'b1, cdb_data[p*32 +: 32]};
    if (acc && m_rob == tag[RW-1:0]) return {1'b1, m_data};
    return 33'd0;
  endfunction

  always @(posedge clk_in) begin
    if (rst_in) begin
      mq.delete(); m_ov = 1'b0; m_rob = '0; m_data = '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        mq.delete(); m_ov = 1'b0;
      end else begin
        m_acc = m_ov && out_ready;
        m_pick = -1;
        foreach (mq[k]) if (m_pick < 0 && mq[k].qj == NON && mq[k].qk == NON) m_pick = k;
        if (m_pick >= 0 && !(!m_ov || out_ready)) m_pick = -1;
        m_alloc = disp_valid && mq.size() < D;
        m_ne.rob = disp_rob_idx; m_ne.op = disp_opcode; m_ne.imm = disp_imm;
        m_ne.vj = disp_vj; m_ne.qj = disp_qj; m_ne.vk = disp_vk; m_ne.qk = disp_qk;
        m_s = m_snoop(disp_qj, m_acc); if (m_s[32]) begin m_ne.qj = NON; m_ne.vj = m_s[31:0]; end
        m_s = m_snoop(disp_qk, m_acc); if (m_s[32]) begin m_ne.qk = NON; m_ne.vk = m_s[31:0]; end
        foreach (mq[k]) begin
          m_e = mq[k];
          m_s = m_snoop(m_e.qj, m_acc); if (m_s[32]) begin m_e.qj = NON; m_e.vj = m_s[31:0]; end
          m_s = m_snoop(m_e.qk, m_acc); if (m_s[32]) begin m_e.qk = NON; m_e.vk = m_s[31:0]; end
          mq[k] = m_e;
        end
        if (m_pick >= 0) begin
          m_ov = 1'b1; m_rob = mq[m_pick].rob; m_data = m_alu(mq[m_pick]);
          mq.delete(m_pick);
        end else if (out_ready) begin
          m_ov = 1'b0;
        end
        if (m_alloc) mq.push_back(m_ne);
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("m_out_rob_idx", 32'(out_rob_idx), 32'(m_rob));
        chk("m_out_data", out_data, m_data);
      end
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_full", 32'(full), 32'(mq.size() == D));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_disp_ready", 32'(disp_ready), 32'(mq.size() < D));
    end
  end

  task automatic disp(input logic [RW-1:0] rob, input logic [6:0] op, input logic [31:0] vj,
                      input logic [31:0] vk, input logic [RW:0] qj, input logic [RW:0] qk,
                      input logic [31:0] imm);
    disp_valid = 1'b1; disp_rob_idx = rob; disp_opcode = op;
    disp_vj = vj; disp_vk = vk; disp_qj = qj; disp_qk = qk; disp_imm = imm;
    @(negedge clk_in);
    disp_valid = 1'b0;
  endtask

  localparam int NS = 29;
  logic [6:0]  s_op  [NS] = '{31, 32, 27, 7, 7, 10, 10, 10, 8, 9, 5, 6, 4, 29, 34, 35, 21, 20,
                              30, 25, 22, 37, 36, 50, 28, 26, 33, 23, 24};
  logic [31:0] s_vj  [NS] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1, 1,
                              32'hFFFFFFFF, 5, 32'hFFFFFFFF, 1, 7, 7, 32'h1001, 3, 32'h80000000,
                              32'h80000000, 0, 32'hFFFFFFFE, 1, 3, 32'hF0, 32'hF0, 32'hF0, 1,
                              32'hFFFFFFFF, 32'hF0, 32'hFF, 32'h100, 32'hFF};
  logic [31:0] s_vk  [NS] = '{1, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5, 32'hFFFFFFFF, 2, 7, 7,
                              0, 5, 32'h21, 4, 0, 0, 31, 0, 0, 32'h3C, 32'h0F, 1, 2, 0, 32'h0F,
                              0, 0};
  logic [31:0] s_imm [NS] = '{0, 0, 33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 0, 32'h22, 32'hFF, 0, 0, 0, 0, 4, 0, 1, 32'h0F};
  logic [31:0] s_exp [NS] = '{1, 0, 32'hC0000000, 1, 0, 0, 1, 1, 1, 1, 1, 0, 32'h1002,
                              32'hFFFFFFFE, 32'h40000000, 32'hF8000000, 1, 1, 32'h80000000,
                              32'hC, 32'h0F, 32'h30, 32'hFF, 0, 1, 32'hF, 32'hF0, 32'h101, 32'h0F};

  int got;
  logic [31:0] vk_e, imm_e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk_in);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rob", 32'(out_rob_idx), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    rst_in = 1'b0;
    @(negedge clk_in);

    // 1: no-dependency addi, 2-cycle latency
    disp(3, 19, 5, 0, NON, NON, 7);
    chk("t1_lat_early", 32'(out_valid), 0);
    @(negedge clk_in);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_rob", 32'(out_rob_idx), 3);
    chk("t1_data", out_data, 12);
    @(negedge clk_in);

    // 2: wakeup on CDB port 1
    disp(1, 28, 0, 4, 5'd2, NON, 0);
    cdb_valid = 2'b10; cdb_idx = {4'd2, 4'd0}; cdb_data = {32'd10, 32'd0};
    @(negedge clk_in);
    cdb_valid = '0;
    chk("t2_wait", 32'(out_valid), 0);
    @(negedge clk_in);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_rob", 32'(out_rob_idx), 1);
    chk("t2_data", out_data, 14);
    @(negedge clk_in);

    // 3: fill, reject extra dispatch, drain in allocation order
    for (int i = 0; i < D; i++) disp(RW'(i), 19, 0, 0, 5'd5, NON, 32'(i));
    chk("t3_full", 32'(full), 1);
    chk("t3_disp_ready", 32'(disp_ready), 0);
    disp(15, 19, 0, 0, NON, NON, 100);
    chk("t3_count_after_extra", 32'(count), 16);
    chk("t3_no_issue", 32'(out_valid), 0);
    cdb_valid = 2'b01; cdb_idx = {4'd0, 4'd5}; cdb_data = {32'd0, 32'd1000};
    @(negedge clk_in);
    cdb_valid = '0;
    chk("t3_wake_only", 32'(out_valid), 0);
    for (int i = 0; i < D; i++) begin
      @(negedge clk_in);
      chk("t3_order_rob", 32'(out_rob_idx), 32'(i));
      chk("t3_order_data", out_data, 32'(1000 + i));
    end
    @(negedge clk_in);
    chk("t3_drained", 32'(empty), 1);

    // 4: back-pressure
    out_ready = 1'b0;
    disp(1, 19, 1, 0, NON, NON, 1);
    disp(2, 19, 2, 0, NON, NON, 2);
    disp(3, 19, 3, 0, NON, NON, 3);
    for (int h = 0; h < 3; h++) begin
      chk("t4_hold_rob", 32'(out_rob_idx), 1);
      chk("t4_hold_data", out_data, 2);
      chk("t4_hold_count", 32'(count), 2);
      @(negedge clk_in);
    end
    out_ready = 1'b1;
    @(negedge clk_in);
    chk("t4_second_rob", 32'(out_rob_idx), 2);
    chk("t4_second_data", out_data, 4);
    @(negedge clk_in);
    chk("t4_third_rob", 32'(out_rob_idx), 3);
    chk("t4_third_data", out_data, 6);
    @(negedge clk_in);
    chk("t4_done", 32'(out_valid), 0);

    // 5: freeze swallows a broadcast and holds the output
    disp(6, 19, 3, 0, NON, NON, 0);
    disp(7, 28, 0, 1, 5'd9, NON, 0);
    rdy_in = 1'b0;
    cdb_valid = 2'b01; cdb_idx = {4'd0, 4'd9}; cdb_data = {32'd0, 32'd20};
    for (int h = 0; h < 2; h++) begin
      @(negedge clk_in);
      chk("t5_frz_valid", 32'(out_valid), 1);
      chk("t5_frz_rob", 32'(out_rob_idx), 6);
      chk("t5_frz_count", 32'(count), 1);
    end
    rdy_in = 1'b1; cdb_valid = '0;
    @(negedge clk_in);
    chk("t5_missed_bcast", 32'(out_valid), 0);
    @(negedge clk_in);
    chk("t5_still_waiting", 32'(count), 1);
    cdb_valid = 2'b10; cdb_idx = {4'd9, 4'd0}; cdb_data = {32'd20, 32'd0};
    @(negedge clk_in);
    cdb_valid = '0;
    @(negedge clk_in);
    chk("t5_rob", 32'(out_rob_idx), 7);
    chk("t5_data", out_data, 21);
    @(negedge clk_in);

    // 5b: flush with a same-cycle dispatch and a stalled output
    out_ready = 1'b0;
    disp(8, 19, 1, 0, NON, NON, 1);
    disp(9, 19, 0, 0, 5'd12, NON, 0);
    chk("t5f_pre_valid", 32'(out_valid), 1);
    flush_in = 1'b1;
    disp(10, 19, 0, 0, NON, NON, 0);
    flush_in = 1'b0;
    chk("t5f_empty", 32'(empty), 1);
    chk("t5f_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    @(negedge clk_in);
    chk("t5f_dropped", 32'(out_valid), 0);

    // 6: opcode sweep, results in dispatch order
    got = 0;
    for (int i = 0; i < NS; i++) begin
      vk_e  = (s_op[i] >= 19 && s_op[i] <= 27) ? 32'h5A5A5A5A : s_vk[i];
      imm_e = (s_op[i] >= 5 && s_op[i] <= 10) || s_op[i] >= 28 ? 32'h13 : s_imm[i];
      disp(RW'(i), s_op[i], s_vj[i], vk_e, NON, NON, imm_e);
      if (out_valid && got < NS) begin
        chk("t6_sweep_data", out_data, s_exp[got]);
        chk("t6_sweep_rob", 32'(out_rob_idx), 32'(got % 16));
        got++;
      end
    end
    for (int c = 0; c < 40 && got < NS; c++) begin
      @(negedge clk_in);
      if (out_valid) begin
        chk("t6_sweep_data", out_data, s_exp[got]);
        chk("t6_sweep_rob", 32'(out_rob_idx), 32'(got % 16));
        got++;
      end
    end
    chk("t6_sweep_count", 32'(got), NS);

    repeat (2) @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
